mc_mem_responder: RTL and testbench

Memory-side responder for the multi-cycle CPU's control FSM. It accepts one read or write request at a time on the `mem_read` / `mem_write` / `iord`-selected address path, then waits a configurable number of cycles. It answers with a single-cycle `mem_ready` pulse, plus read data or an error flag. It sits between the datapath's address/write-data mux and the unified instruction/data word store, and lets the control FSM hold in a wait state instead of assuming single-cycle memory.

---
 rtl/mem_resp_pkg.sv | 24 ++
 rtl/mc_mem_responder_if.sv | 23 ++
 rtl/word_ram.sv | 27 ++
 rtl/mc_mem_responder.sv | 114 +++++++++++
 tb/tb_mc_mem_responder.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the multi-cycle CPU memory responder.
//   state_e   : responder FSM states (2-bit encoding)
//   req_t     : latched copy of an accepted request
//   WORD_W    : data/address word width
//   CNT_W     : latency down-counter width
//   MAX_LATENCY : largest legal LATENCY value (fits in CNT_W bits)
package mem_resp_pkg;
   localparam int WORD_W      = 32;
   localparam int CNT_W       = 4;
   localparam int MAX_LATENCY = 15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic              rd;
      logic              wr;
      logic [WORD_W-1:0] addr;
      logic [WORD_W-1:0] din;
   } req_t;
endpackage

// File: rtl/mc_mem_responder_if.sv
// Request/response bus between the CPU control path (master) and the
// memory responder (slave).
//   mem_read / mem_write : request, held by the master until mem_ready
//   addr / din           : word-aligned byte address and write data
//   dout                 : read data, valid with mem_ready
//   mem_ready            : one-cycle completion pulse
//   mem_err              : qualifies mem_ready, request rejected
//   busy                 : responder not idle
interface mc_mem_responder_if import mem_resp_pkg::*; ();
   logic              mem_read;
   logic              mem_write;
   logic [WORD_W-1:0] addr;
   logic [WORD_W-1:0] din;
   logic [WORD_W-1:0] dout;
   logic              mem_ready;
   logic              mem_err;
   logic              busy;

   modport master (output mem_read, mem_write, addr, din,
                   input  dout, mem_ready, mem_err, busy);
   modport slave  (input  mem_read, mem_write, addr, din,
                   output dout, mem_ready, mem_err, busy);
endinterface

// File: rtl/word_ram.sv
// Unified instruction/data word store: synchronous write, synchronous read.
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write word index
//   wdata : write data
//   raddr : read word index
//   rdata : registered read data (read-before-write on the same edge)
// Contents are not reset.
module word_ram #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10,
   parameter int W     = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/mc_mem_responder.sv
// Memory-side responder for the multi-cycle CPU control FSM. Accepts one
// request at a time, waits LATENCY cycles, then answers with a one-cycle
// mem_ready pulse carrying read data or an error flag.
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : slave side of mc_mem_responder_if
// Parameters: DEPTH words of storage, LATENCY (1..MAX_LATENCY) cycles from
// acceptance to mem_ready.
module mc_mem_responder import mem_resp_pkg::*; #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic               clk,
   input  logic               reset,
   mc_mem_responder_if.slave  bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   req_t              req_q, req_d;
   logic              ready_q, ready_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic [WORD_W-1:0] dout_q, dout_d;

   logic              req_err;
   logic              fire;
   logic              ram_we;
   logic [AW-1:0]     raddr;
   logic [WORD_W-1:0] rdata;

   // Error check is evaluated on the latched request only.
   assign req_err = (req_q.addr[1:0] != 2'b00) ||
                    ({2'b00, req_q.addr[WORD_W-1:2]} >= 32'(DEPTH)) ||
                    (req_q.rd && req_q.wr);

   // Last WAIT cycle: the next edge enters RESP.
   assign fire   = (state_q == WAIT) && (cnt_q == '0);
   assign ram_we = fire && req_q.wr && !req_err && reset;

   // The RAM read register must hold the target word by the edge entering
   // RESP. In IDLE the live address is used so that LATENCY=1 (whose only
   // WAIT edge is the RESP-entry edge) still sees the right word.
   assign raddr = (state_q == IDLE) ? bus.addr[AW+1:2] : req_q.addr[AW+1:2];

   word_ram #(.DEPTH(DEPTH), .AW(AW), .W(WORD_W)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (req_q.addr[AW+1:2]),
      .wdata (req_q.din),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      ready_d = 1'b0;
      err_d   = 1'b0;
      dout_d  = dout_q;
      case (state_q)
         IDLE: begin
            if (bus.mem_read || bus.mem_write) begin
               state_d = WAIT;
               cnt_d   = CNT_W'(LATENCY - 1);
               req_d   = '{rd: bus.mem_read, wr: bus.mem_write,
                           addr: bus.addr, din: bus.din};
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
               ready_d = 1'b1;
               err_d   = req_err;
               if (req_err)    dout_d = '0;
               else if (req_q.rd) dout_d = rdata;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         // RESP ignores any request still held from this transaction.
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         dout_q  <= dout_d;
      end
   end

   assign bus.dout      = dout_q;
   assign bus.mem_ready = ready_q;
   assign bus.mem_err   = err_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mc_mem_responder.sv
// Directed bench for mc_mem_responder. Three instances share clk/reset with
// LATENCY = 2, 1 and 15. Expected responses are queued when a request is
// driven and compared when mem_ready is observed. Outputs are sampled on
// the falling edge; inputs change on the falling edge.
module tb_mc_mem_responder;
   localparam int DEPTH = 1024;
   localparam int LAT [3] = '{2, 1, 15};

   typedef struct {
      string       tag;
      logic        err;
      logic        chk_d;
      logic [31:0] dout;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        rd  [3];
   logic        wr  [3];
   logic [31:0] ad  [3];
   logic [31:0] di  [3];
   logic        rdy [3];
   logic        err [3];
   logic        bsy [3];
   logic [31:0] dq  [3];

   int   passed = 0;
   int   failed = 0;
   int   total  = 0;
   exp_t sb[$];

   mc_mem_responder_if b0 ();
   mc_mem_responder_if b1 ();
   mc_mem_responder_if b2 ();

   assign b0.mem_read = rd[0]; assign b0.mem_write = wr[0];
   assign b0.addr = ad[0];     assign b0.din = di[0];
   assign rdy[0] = b0.mem_ready; assign err[0] = b0.mem_err;
   assign bsy[0] = b0.busy;      assign dq[0]  = b0.dout;

   assign b1.mem_read = rd[1]; assign b1.mem_write = wr[1];
   assign b1.addr = ad[1];     assign b1.din = di[1];
   assign rdy[1] = b1.mem_ready; assign err[1] = b1.mem_err;
   assign bsy[1] = b1.busy;      assign dq[1]  = b1.dout;

   assign b2.mem_read = rd[2]; assign b2.mem_write = wr[2];
   assign b2.addr = ad[2];     assign b2.din = di[2];
   assign rdy[2] = b2.mem_ready; assign err[2] = b2.mem_err;
   assign bsy[2] = b2.busy;      assign dq[2]  = b2.dout;

   mc_mem_responder #(.DEPTH(DEPTH), .LATENCY(2))  dut0 (.clk(clk), .reset(reset), .bus(b0));
   mc_mem_responder #(.DEPTH(DEPTH), .LATENCY(1))  dut1 (.clk(clk), .reset(reset), .bus(b1));
   mc_mem_responder #(.DEPTH(DEPTH), .LATENCY(15)) dut2 (.clk(clk), .reset(reset), .bus(b2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge with the target instance idle. The request is
   // accepted at the next rising edge (edge 0); n counts edges since then.
   task automatic xact(input int d, input string tag, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic e_err, input logic chk_d, input logic [31:0] e_d);
      int   got;
      int   nb;
      exp_t e;
      sb.push_back('{tag: tag, err: e_err, chk_d: chk_d, dout: e_d});
      rd[d] = r; wr[d] = w; ad[d] = a; di[d] = wd;
      got = -1;
      nb  = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (bsy[d]) nb++;
         if (rdy[d]) begin
            got = n;
            break;
         end
      end
      rd[d] = 1'b0; wr[d] = 1'b0;
      chk({tag, " latency"}, 32'(got), 32'(LAT[d]));
      chk({tag, " busy cycles"}, 32'(nb), 32'(LAT[d] + 1));
      e = sb.pop_front();
      if (got >= 0) begin
         chk({e.tag, " err"}, {31'd0, err[d]}, {31'd0, e.err});
         if (e.chk_d) chk({e.tag, " dout"}, dq[d], e.dout);
      end
      @(negedge clk);
      chk({tag, " ready one cycle"}, {31'd0, rdy[d]}, 32'd0);
      chk({tag, " idle after"}, {31'd0, bsy[d]}, 32'd0);
   endtask

   initial begin
      int seen, first, second;
      for (int i = 0; i < 3; i++) begin
         rd[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; di[i] = '0;
      end

      // Reset held for two edges with a read pending.
      reset = 1'b0;
      rd[0] = 1'b1; ad[0] = 32'h13;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("rst ready", {31'd0, rdy[0]}, 32'd0);
         chk("rst busy",  {31'd0, bsy[0]}, 32'd0);
         chk("rst dout",  dq[0], 32'd0);
      end
      reset = 1'b1;
      // First edge with reset high accepts the held (misaligned) read.
      xact(0, "rst-accept misaligned rd", 1'b1, 1'b0, 32'h13, 32'h0, 1'b1, 1'b1, 32'h0);

      // Write then read, LATENCY=2. dout keeps its previous value on a write.
      xact(0, "wr 0x10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0);
      xact(0, "rd 0x10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);

      // Out-of-range write must not alias onto word 0.
      xact(0, "wr 0x0",   1'b0, 1'b1, 32'h0, 32'h11111111, 1'b0, 1'b1, 32'hDEADBEEF);
      xact(0, "wr oob",   1'b0, 1'b1, 32'(4 * DEPTH), 32'h0BAD0BAD, 1'b1, 1'b1, 32'h0);
      xact(0, "rd 0x0",   1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h11111111);

      // Read and write together is rejected and does not write.
      xact(0, "rd+wr",    1'b1, 1'b1, 32'h10, 32'h55555555, 1'b1, 1'b1, 32'h0);
      xact(0, "rd 0x10 again", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);

      // Reset one edge after acceptance drops the pending write.
      xact(0, "wr 0x20 old", 1'b0, 1'b1, 32'h20, 32'hAAAA5555, 1'b0, 1'b0, 32'h0);
      wr[0] = 1'b1; ad[0] = 32'h20; di[0] = 32'h12345678;
      @(negedge clk);
      chk("midrst busy", {31'd0, bsy[0]}, 32'd1);
      reset = 1'b0;
      @(negedge clk);
      chk("midrst ready", {31'd0, rdy[0]}, 32'd0);
      chk("midrst busy cleared", {31'd0, bsy[0]}, 32'd0);
      reset = 1'b1; wr[0] = 1'b0;
      seen = 0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (rdy[0]) seen++;
      end
      chk("midrst no ready", 32'(seen), 32'd0);
      xact(0, "rd 0x20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'hAAAA5555);

      // Held read: one ready per acceptance, re-acceptance at edge L+2.
      rd[0] = 1'b1; ad[0] = 32'h10;
      seen = 0; first = -1; second = -1;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (n == LAT[0] + 2) rd[0] = 1'b0;
         if (rdy[0]) begin
            seen++;
            if (first < 0) first = n;
            else           second = n;
         end
      end
      chk("held ready count", 32'(seen), 32'd2);
      chk("held first ready", 32'(first), 32'(LAT[0]));
      chk("held second ready", 32'(second), 32'(2 * LAT[0] + 2));
      chk("held dout", dq[0], 32'hDEADBEEF);

      // LATENCY=1 and LATENCY=15 instances.
      xact(1, "L1 wr",  1'b0, 1'b1, 32'h40, 32'hCAFE0001, 1'b0, 1'b1, 32'h0);
      xact(1, "L1 rd",  1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 32'hCAFE0001);
      xact(2, "L15 wr", 1'b0, 1'b1, 32'h44, 32'hCAFE000F, 1'b0, 1'b1, 32'h0);
      xact(2, "L15 rd", 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b1, 32'hCAFE000F);
      xact(2, "L15 misaligned", 1'b1, 1'b0, 32'h46, 32'h0, 1'b1, 1'b1, 32'h0);

      chk("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
